polybius_msg_ctrl: RTL and testbench

Byte-serial sequencer for the block-parallel `encryptor`/`decryptor` pair. It collects a message of up to `MSG_LEN` characters over a valid/ready input stream, applies one of the two transforms (selected per message), registers the result, and streams it out over a valid/ready output stream. It lets the rest of the design share one encryptor and one decryptor instance through a single stream interface, with no array-wide ports.

---
 rtl/polybius_msg_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_polybius_msg_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polybius_msg_ctrl.sv
// polybius_msg_ctrl: byte-serial front end for the block-parallel Polybius
// encryptor/decryptor pair. It collects a message of MSG_LEN characters,
// transforms it in one CALC cycle and streams the result back out.
// The encryptor/decryptor cores are defined in this file as well.
// Optional feature macro: POLYBIUS_SELFCHECK_EN (round-trip self check).

// Keyed 5x5 Polybius square over "ABCDEFGHIKLMNOPQRSTUVWXYZ" (J folds into I),
// rotated by SEC_LEN cells. A letter becomes row*10+col (rows/cols 1..5);
// anything that is not an upper-case letter passes through unchanged.
module encryptor #(
    parameter int MSG_LEN = 5,
    parameter int SEC_LEN = 7
) (
    input  logic [MSG_LEN-1:0][7:0] pt,
    output logic [MSG_LEN-1:0][7:0] ct
);
    function automatic logic [7:0] enc_char(input logic [7:0] c);
        int li;
        int p;
        if (c >= 8'h41 && c <= 8'h5A) begin
            li = int'(c) - 65;
            if (li > 9) li = li - 1;
            else if (li == 9) li = 8;
            p = (li + (SEC_LEN % 25)) % 25;
            return 8'((p / 5 + 1) * 10 + (p % 5) + 1);
        end
        return c;
    endfunction

    // Every character is transformed independently.
    always_comb begin
        for (int i = 0; i < MSG_LEN; i++) ct[i] = enc_char(pt[i]);
    end
endmodule

// Inverse of encryptor: valid row*10+col codes map back to letters,
// every other byte passes through unchanged.
module decryptor #(
    parameter int MSG_LEN = 5,
    parameter int SEC_LEN = 7
) (
    input  logic [MSG_LEN-1:0][7:0] ct,
    output logic [MSG_LEN-1:0][7:0] pt
);
    function automatic logic [7:0] dec_char(input logic [7:0] c);
        int r;
        int k;
        int p;
        int li;
        r = int'(c) / 10;
        k = int'(c) % 10;
        if (r >= 1 && r <= 5 && k >= 1 && k <= 5) begin
            p  = (r - 1) * 5 + (k - 1);
            li = (p + 25 - (SEC_LEN % 25)) % 25;
            return (li < 9) ? 8'(65 + li) : 8'(66 + li);
        end
        return c;
    endfunction

    // Every code is transformed independently.
    always_comb begin
        for (int i = 0; i < MSG_LEN; i++) pt[i] = dec_char(ct[i]);
    end
endmodule

module polybius_msg_ctrl #(
    parameter int          MSG_LEN  = 5,
    parameter int          SEC_LEN  = 7,
    parameter logic [7:0]  PAD_CHAR = 8'h58
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_mode,
    output logic       busy,
    output logic       selfchk_err
);
    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      mode_q, mode_d;
    logic                      err_q, err_d;
    logic [MSG_LEN-1:0][7:0]   msg_buf_q, msg_buf_d;
    logic [MSG_LEN-1:0][7:0]   obuf_q, obuf_d;
    logic [MSG_LEN-1:0][7:0]   enc_out, dec_out;
    logic [0:0][7:0]           pad_code;
    logic [7:0]                pad_byte;
    logic                      chk_mismatch;
    logic                      in_hs, out_hs;

    encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_enc (.pt(msg_buf_q), .ct(enc_out));
    decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_dec (.ct(msg_buf_q), .pt(dec_out));
    // Constant cipher code of the pad character, used to pad short decrypt messages.
    encryptor #(.MSG_LEN(1), .SEC_LEN(SEC_LEN)) u_pad (.pt(PAD_CHAR), .ct(pad_code));

`ifdef POLYBIUS_SELFCHECK_EN
    logic [MSG_LEN-1:0][7:0] chk_out;
    decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_chk (.ct(enc_out), .pt(chk_out));
    assign chk_mismatch = (chk_out != msg_buf_q);
`else
    assign chk_mismatch = 1'b0;
`endif

    // Next-state, buffer updates and stream outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        err_d     = err_q;
        msg_buf_d = msg_buf_q;
        obuf_d    = obuf_q;
        in_ready  = (state_q == IDLE) || (state_q == LOAD);
        out_valid = (state_q == DRAIN);
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        // Pad mode comes from the live input on the first byte, else the latched mode.
        pad_byte  = (((state_q == IDLE) ? mode : mode_q) == 1'b1) ? pad_code[0] : PAD_CHAR;

        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    msg_buf_d[0] = in_data;
                    mode_d       = mode;
                    idx_d        = IDX_W'(1);
                    if (in_last || MSG_LEN == 1) begin
                        for (int i = 1; i < MSG_LEN; i++) msg_buf_d[i] = pad_byte;
                        state_d = CALC;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_hs) begin
                    for (int i = 0; i < MSG_LEN; i++) begin
                        if (idx_q == IDX_W'(i)) msg_buf_d[i] = in_data;
                        else if (in_last && int'(idx_q) < i) msg_buf_d[i] = pad_byte;
                    end
                    // The final index is never incremented past, so idx cannot wrap.
                    if (in_last || idx_q == LAST_IDX) state_d = CALC;
                    else idx_d = idx_q + IDX_W'(1);
                end
            end
            CALC: begin
                obuf_d  = mode_q ? dec_out : enc_out;
                if (!mode_q && chk_mismatch) err_d = 1'b1;
                idx_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_hs) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        out_data = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (state_q == DRAIN && idx_q == IDX_W'(i)) out_data = obuf_q[i];
        end
        out_last    = (state_q == DRAIN) && (idx_q == LAST_IDX);
        out_mode    = mode_q;
        busy        = (state_q != IDLE);
        selfchk_err = err_q;
    end

    // State, index and buffer registers; reset discards any message in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            msg_buf_q <= '0;
            obuf_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            msg_buf_q <= msg_buf_d;
            obuf_q    <= obuf_d;
        end
    end
endmodule

// File: tb/tb_polybius_msg_ctrl.sv
// Testbench for polybius_msg_ctrl: scoreboard of expected output bytes,
// one task per scenario, summary line at the end.
module tb_polybius_msg_ctrl;
    logic       clk = 1'b0;
    logic       rst, mode, in_valid, in_ready, in_last;
    logic       out_valid, out_ready, out_last, out_mode, busy, selfchk_err;
    logic [7:0] in_data, out_data;

    polybius_msg_ctrl dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_mode(out_mode), .busy(busy),
        .selfchk_err(selfchk_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];
    int         first_valid;
    bit         rdy_during;
    logic       mode_seen;
    int         hold_bad;

    // Known ciphertext of "HELLO" for the rotated square (SEC_LEN = 7).
    logic [7:0] hello_ct [5] = '{8'd35, 8'd32, 8'd43, 8'd43, 8'd51};

    // Reference cipher: search the keyed alphabet string for the letter.
    function automatic logic [7:0] m_enc(input logic [7:0] c);
        string sq = "ABCDEFGHIKLMNOPQRSTUVWXYZ";
        logic [7:0] cc;
        int pos = -1;
        cc = (c == "J") ? 8'h49 : c;
        for (int i = 0; i < 25; i++) if (8'(sq[i]) == cc) pos = i;
        if (pos < 0) return c;
        pos = (pos + 7) % 25;
        return 8'((pos / 5 + 1) * 10 + (pos % 5) + 1);
    endfunction

    function automatic logic [7:0] m_dec(input logic [7:0] c);
        string sq = "ABCDEFGHIKLMNOPQRSTUVWXYZ";
        int cv = int'(c);
        int r  = cv / 10;
        int k  = cv % 10;
        int pos;
        if (r < 1 || r > 5 || k < 1 || k > 5) return c;
        pos = ((r - 1) * 5 + (k - 1) + 25 - 7) % 25;
        return 8'(sq[pos]);
    endfunction

    // Streams a message in and pushes its expected output bytes.
    task automatic send_msg(input logic [7:0] m[$], input logic md, input logic md_later);
        int len = m.size();
        logic [7:0] ch;
        for (int i = 0; i < 5; i++) begin
            ch = (i < len) ? m[i] : (md ? m_enc(8'h58) : 8'h58);
            exp_q.push_back(md ? m_dec(ch) : m_enc(ch));
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = m[i];
            in_last  = (i == len - 1) && (len < 5);
            mode     = (i == 0) ? md : md_later;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drains up to n bytes; bp applies the 1,0,0,1 out_ready pattern.
    task automatic collect(input int n, input bit bp);
        int   cyc = 0;
        int   k = 0;
        bit   prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        logic prev_last = 1'b0;
        first_valid = -1;
        rdy_during  = 0;
        hold_bad    = 0;
        while (got_q.size() < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (in_ready) rdy_during = 1;
            out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                mode_seen = out_mode;
                if (prev_stall && (out_data !== prev_data || out_last !== prev_last)) hold_bad++;
                prev_stall = !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                k++;
                if (out_ready) begin
                    got_q.push_back(out_data);
                    got_last_q.push_back(out_last);
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, out_last, out_mode, busy, selfchk_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {in_ready, out_valid, out_last, out_mode, busy, selfchk_err});
        end
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00", out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_encrypt;
        logic [7:0] m[$];
        logic [7:0] e, g;
        logic l;
        m = '{"H", "E", "L", "L", "O"};
        send_msg(m, 1'b0, 1'b0);
        collect(5, 1'b0);
        n_checks++;
        if (first_valid !== 2) begin
            n_fail++; $display("FAIL enc_latency: got %0d expected 2", first_valid);
        end
        n_checks++;
        if (rdy_during !== 1'b0) begin
            n_fail++; $display("FAIL enc_in_ready: got %0d expected 0", rdy_during);
        end
        n_checks++;
        if (got_q.size() !== 5) begin
            n_fail++; $display("FAIL enc_count: got %0d expected 5", got_q.size());
        end
        for (int i = 0; got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = got_last_q.pop_front();
            n_checks++;
            if (g !== e || g !== hello_ct[i]) begin
                n_fail++; $display("FAIL enc_byte%0d: got %0d expected %0d", i, g, hello_ct[i]);
            end
            n_checks++;
            if (l !== (i == 4)) begin
                n_fail++; $display("FAIL enc_last%0d: got %b expected %b", i, l, (i == 4));
            end
        end
        exp_q.delete();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL enc_idle_after: got ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_round_trip;
        logic [7:0] m[$];
        logic [7:0] g;
        string hello = "HELLO";
        logic l;
        m = '{hello_ct[0], hello_ct[1], hello_ct[2], hello_ct[3], hello_ct[4]};
        send_msg(m, 1'b1, 1'b1);
        collect(5, 1'b0);
        n_checks++;
        if (got_q.size() !== 5) begin
            n_fail++; $display("FAIL rt_count: got %0d expected 5", got_q.size());
        end
        for (int i = 0; got_q.size() > 0; i++) begin
            void'(exp_q.pop_front()); g = got_q.pop_front(); l = got_last_q.pop_front();
            n_checks++;
            if (g !== 8'(hello[i])) begin
                n_fail++; $display("FAIL rt_byte%0d: got %h expected %h", i, g, 8'(hello[i]));
            end
            n_checks++;
            if (l !== (i == 4)) begin
                n_fail++; $display("FAIL rt_last%0d: got %b expected %b", i, l, (i == 4));
            end
        end
        exp_q.delete();
        n_checks++;
        if (mode_seen !== 1'b1) begin
            n_fail++; $display("FAIL rt_out_mode: got %b expected 1", mode_seen);
        end
        n_checks++;
        if (selfchk_err !== 1'b0) begin
            n_fail++; $display("FAIL rt_selfchk: got %b expected 0", selfchk_err);
        end
    endtask

    task automatic test_short;
        logic [7:0] m[$];
        logic [7:0] e, g;
        logic l;
        m = '{"H", "I"};
        send_msg(m, 1'b0, 1'b0);
        collect(5, 1'b0);
        n_checks++;
        if (got_q.size() !== 5) begin
            n_fail++; $display("FAIL short_count: got %0d expected 5", got_q.size());
        end
        for (int i = 0; got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = got_last_q.pop_front();
            n_checks++;
            if (g !== e || (i >= 2 && g !== 8'd15)) begin
                n_fail++; $display("FAIL short_byte%0d: got %0d expected %0d", i, g, e);
            end
            n_checks++;
            if (l !== (i == 4)) begin
                n_fail++; $display("FAIL short_last%0d: got %b expected %b", i, l, (i == 4));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure;
        logic [7:0] m[$];
        logic [7:0] e, g;
        logic l;
        m = '{"H", "E", "L", "L", "O"};
        send_msg(m, 1'b0, 1'b0);
        collect(5, 1'b1);
        n_checks++;
        if (hold_bad !== 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d changes while stalled expected 0", hold_bad);
        end
        n_checks++;
        if (got_q.size() !== 5) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 5", got_q.size());
        end
        for (int i = 0; got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = got_last_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL bp_byte%0d: got %0d expected %0d", i, g, e);
            end
            n_checks++;
            if (l !== (i == 4)) begin
                n_fail++; $display("FAIL bp_last%0d: got %b expected %b", i, l, (i == 4));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_drain;
        logic [7:0] m[$];
        logic [7:0] e, g;
        logic l;
        m = '{"H", "E", "L", "L", "O"};
        send_msg(m, 1'b0, 1'b0);
        collect(2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, in_ready, out_last} !== 4'b0010 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_state: got valid=%b busy=%b ready=%b last=%b data=%h expected 0 0 1 0 00",
                     out_valid, busy, in_ready, out_last, out_data);
        end
        rst = 1'b0;
        for (int i = 0; got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); void'(got_last_q.pop_front());
            n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL rstmid_pre%0d: got %0d expected %0d", i, g, e);
            end
        end
        exp_q.delete();
        send_msg(m, 1'b0, 1'b0);
        collect(5, 1'b0);
        n_checks++;
        if (got_q.size() !== 5) begin
            n_fail++; $display("FAIL rstmid_count: got %0d expected 5", got_q.size());
        end
        for (int i = 0; got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = got_last_q.pop_front();
            n_checks++;
            if (g !== e || l !== (i == 4)) begin
                n_fail++; $display("FAIL rstmid_byte%0d: got %0d/%b expected %0d/%b", i, g, l, e, (i == 4));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_mode_latch;
        logic [7:0] m[$];
        logic [7:0] g;
        m = '{"H", "E", "L", "L", "O"};
        send_msg(m, 1'b0, 1'b1);
        collect(5, 1'b0);
        n_checks++;
        if (mode_seen !== 1'b0) begin
            n_fail++; $display("FAIL latch_out_mode: got %b expected 0", mode_seen);
        end
        n_checks++;
        if (got_q.size() !== 5) begin
            n_fail++; $display("FAIL latch_count: got %0d expected 5", got_q.size());
        end
        for (int i = 0; got_q.size() > 0; i++) begin
            void'(exp_q.pop_front()); g = got_q.pop_front(); void'(got_last_q.pop_front());
            n_checks++;
            if (g !== hello_ct[i]) begin
                n_fail++; $display("FAIL latch_byte%0d: got %0d expected %0d", i, g, hello_ct[i]);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; out_ready = 1'b1; mode_seen = 1'b0;
        test_reset();
        test_encrypt();
        test_round_trip();
        test_short();
        test_backpressure();
        test_reset_mid_drain();
        test_mode_latch();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
